flash_prog_ctrl: RTL and testbench

Command sequencer that programs and erases the on-board 16-bit parallel NOR flash (AMD/JEDEC command set) on behalf of a software-visible command port. It sits between the CPU-side register decode and the flash pins, and owns flash WE/OE/CE while a command runs. It generates the unlock/command bus cycles, tracks FLASH_BUSY_n through completion, and reports done/error.

---
 rtl/flash_prog_ctrl.sv | 270 +++++++++++++++++++++++++++
 tb/tb_flash_prog_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_prog_ctrl.sv
// flash_prog_ctrl: issues AMD/JEDEC unlock and command write cycles to a
// 16-bit parallel NOR flash, then tracks FLASH_BUSY_n until the embedded
// operation finishes and reports done/error.
//
// Optional feature macro: FLASH_PROG_VERIFY_EN. When it is defined, each
// program command reads the target word back and flags a mismatch as an error.
//
// Ports:
//   CLKCPU, RESET          clock, synchronous active-high reset
//   cmd_valid/cmd_ready    command handshake (ready only while idle)
//   cmd_op/addr/data       operation (00 prog, 01 sector erase, 10 chip erase,
//                          11 read/reset), word address, program data
//   FLASH_BUSY_n, flash_q  flash RY/BY# and read data
//   flash_a/d/d_oe         flash address, write data, data bus drive enable
//   flash_ce_n/we_n/oe_n   flash strobes
//   busy, done, error      status: not idle, completion pulse, failure flag
module flash_prog_ctrl #(
    parameter int unsigned WE_CYC    = 2,
    parameter int unsigned BSY_WAIT  = 8,
    parameter int unsigned TIMEOUT_W = 24,
    parameter int unsigned RD_CYC    = 3
) (
    input  logic        CLKCPU,
    input  logic        RESET,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [19:0] cmd_addr,
    input  logic [15:0] cmd_data,
    input  logic        FLASH_BUSY_n,
    input  logic [15:0] flash_q,
    output logic [19:0] flash_a,
    output logic [15:0] flash_d,
    output logic        flash_d_oe,
    output logic        flash_ce_n,
    output logic        flash_we_n,
    output logic        flash_oe_n,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam int unsigned PW = $clog2(WE_CYC + 1);
    localparam int unsigned BW = $clog2(BSY_WAIT + 1);

    localparam logic [1:0] OP_PROG = 2'b00;
    localparam logic [1:0] OP_CE   = 2'b10;
    localparam logic [1:0] OP_RR   = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_NEXT,
        S_WAIT_BSY,
        S_WAIT_RDY,
`ifdef FLASH_PROG_VERIFY_EN
        S_VERIFY,
`endif
        S_FINISH
    } state_t;

    state_t                 state_q;
    logic [1:0]             op_q;
    logic [19:0]            addr_q;
    logic [15:0]            data_q;
    logic [2:0]             idx_q;
    logic [PW-1:0]          pcnt_q;
    logic [BW-1:0]          bcnt_q;
    logic [TIMEOUT_W-1:0]   tcnt_q;
    logic [2:0]             idx_d;

    assign idx_d = idx_q + 3'd1;

    // Number of bus writes in each command sequence.
    function automatic logic [2:0] seq_len(input logic [1:0] op);
        case (op)
            OP_PROG: return 3'd4;
            OP_RR:   return 3'd1;
            default: return 3'd6;
        endcase
    endfunction

    // Address of write idx; the target address replaces PA/SA slots.
    function automatic logic [19:0] seq_addr(input logic [1:0] op, input logic [2:0] idx,
                                             input logic [19:0] tgt);
        logic [19:0] a;
        case (idx)
            3'd0, 3'd2: a = 20'h00555;
            3'd1, 3'd4: a = 20'h002AA;
            3'd3:       a = (op == OP_PROG) ? tgt : 20'h00555;
            default:    a = (op == OP_CE) ? 20'h00555 : tgt;
        endcase
        if (op == OP_RR) a = tgt;
        return a;
    endfunction

    // Data of write idx.
    function automatic logic [15:0] seq_data(input logic [1:0] op, input logic [2:0] idx,
                                             input logic [15:0] wd);
        logic [15:0] d;
        case (idx)
            3'd0:       d = 16'h00AA;
            3'd1, 3'd4: d = 16'h0055;
            3'd2:       d = (op == OP_PROG) ? 16'h00A0 : 16'h0080;
            3'd3:       d = (op == OP_PROG) ? wd : 16'h00AA;
            default:    d = (op == OP_CE) ? 16'h0010 : 16'h0030;
        endcase
        if (op == OP_RR) d = 16'h00F0;
        return d;
    endfunction

`ifdef FLASH_PROG_VERIFY_EN
    localparam int unsigned RW = $clog2(RD_CYC + 1);
    logic [RW-1:0] vcnt_q;
`else
    logic unused_ok;
    assign unused_ok = ^flash_q ^ RD_CYC[0];
`endif

    // Sequencer state, counters and all registered outputs.
    always_ff @(posedge CLKCPU) begin
        if (RESET) begin
            state_q    <= S_IDLE;
            op_q       <= 2'b00;
            addr_q     <= 20'h0;
            data_q     <= 16'h0;
            idx_q      <= 3'd0;
            pcnt_q     <= '0;
            bcnt_q     <= '0;
            tcnt_q     <= '0;
`ifdef FLASH_PROG_VERIFY_EN
            vcnt_q     <= '0;
`endif
            cmd_ready  <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            flash_a    <= 20'h0;
            flash_d    <= 16'h0;
            flash_d_oe <= 1'b0;
            flash_ce_n <= 1'b1;
            flash_we_n <= 1'b1;
            flash_oe_n <= 1'b1;
        end else begin
            done <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        state_q    <= S_SETUP;
                        op_q       <= cmd_op;
                        addr_q     <= cmd_addr;
                        data_q     <= cmd_data;
                        idx_q      <= 3'd0;
                        error      <= 1'b0;
                        cmd_ready  <= 1'b0;
                        busy       <= 1'b1;
                        flash_ce_n <= 1'b0;
                        flash_d_oe <= 1'b1;
                        flash_a    <= seq_addr(cmd_op, 3'd0, cmd_addr);
                        flash_d    <= seq_data(cmd_op, 3'd0, cmd_data);
                    end
                end
                S_SETUP: begin
                    state_q    <= S_PULSE;
                    flash_we_n <= 1'b0;
                    pcnt_q     <= '0;
                end
                S_PULSE: begin
                    if (pcnt_q == PW'(WE_CYC - 1)) begin
                        state_q    <= S_HOLD;
                        flash_we_n <= 1'b1;
                    end else begin
                        pcnt_q <= pcnt_q + PW'(1);
                    end
                end
                S_HOLD: begin
                    state_q    <= S_NEXT;
                    flash_d_oe <= 1'b0;
                end
                S_NEXT: begin
                    idx_q <= idx_d;
                    if (op_q == OP_RR) begin
                        state_q    <= S_FINISH;
                        flash_ce_n <= 1'b1;
                        done       <= 1'b1;
                    end else if (idx_d < seq_len(op_q)) begin
                        state_q    <= S_SETUP;
                        flash_d_oe <= 1'b1;
                        flash_a    <= seq_addr(op_q, idx_d, addr_q);
                        flash_d    <= seq_data(op_q, idx_d, data_q);
                    end else begin
                        state_q <= S_WAIT_BSY;
                        bcnt_q  <= '0;
                    end
                end
                // A flash that never reports busy is treated as already complete.
                S_WAIT_BSY: begin
                    if (!FLASH_BUSY_n) begin
                        state_q <= S_WAIT_RDY;
                        tcnt_q  <= '0;
                    end else if (bcnt_q == BW'(BSY_WAIT - 1)) begin
`ifdef FLASH_PROG_VERIFY_EN
                        if (op_q == OP_PROG) begin
                            state_q    <= S_VERIFY;
                            flash_oe_n <= 1'b0;
                            vcnt_q     <= '0;
                        end else
`endif
                        begin
                            state_q    <= S_FINISH;
                            flash_ce_n <= 1'b1;
                            done       <= 1'b1;
                        end
                    end else begin
                        bcnt_q <= bcnt_q + BW'(1);
                    end
                end
                // Timeout fires as the counter would reach all-ones.
                S_WAIT_RDY: begin
                    if (FLASH_BUSY_n) begin
`ifdef FLASH_PROG_VERIFY_EN
                        if (op_q == OP_PROG) begin
                            state_q    <= S_VERIFY;
                            flash_oe_n <= 1'b0;
                            vcnt_q     <= '0;
                        end else
`endif
                        begin
                            state_q    <= S_FINISH;
                            flash_ce_n <= 1'b1;
                            done       <= 1'b1;
                        end
                    end else if (tcnt_q == ~TIMEOUT_W'(1)) begin
                        state_q    <= S_FINISH;
                        flash_ce_n <= 1'b1;
                        done       <= 1'b1;
                        error      <= 1'b1;
                    end else begin
                        tcnt_q <= tcnt_q + TIMEOUT_W'(1);
                    end
                end
`ifdef FLASH_PROG_VERIFY_EN
                // Read-back: compare on the last cycle of the OE pulse.
                S_VERIFY: begin
                    if (vcnt_q == RW'(RD_CYC - 1)) begin
                        state_q    <= S_FINISH;
                        flash_oe_n <= 1'b1;
                        flash_ce_n <= 1'b1;
                        done       <= 1'b1;
                        error      <= (flash_q != data_q);
                    end else begin
                        vcnt_q <= vcnt_q + RW'(1);
                    end
                end
`endif
                S_FINISH: begin
                    state_q   <= S_IDLE;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flash_prog_ctrl.sv
// Bench for flash_prog_ctrl: scenario tasks drive commands and a FLASH_BUSY_n
// profile, and compare the bus writes, completion cycle and error flag against
// a timeline model built from the command tables and wait rules.
module tb_flash_prog_ctrl;

    localparam int WE   = 2;
    localparam int BSYW = 8;
    localparam int TW   = 8;
    localparam int RD   = 3;

    logic        CLKCPU = 1'b0;
    logic        RESET;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [19:0] cmd_addr;
    logic [15:0] cmd_data;
    logic        FLASH_BUSY_n;
    logic [15:0] flash_q;
    logic [19:0] flash_a;
    logic [15:0] flash_d;
    logic        flash_d_oe;
    logic        flash_ce_n;
    logic        flash_we_n;
    logic        flash_oe_n;
    logic        busy;
    logic        done;
    logic        error;

    always #5 CLKCPU = ~CLKCPU;

    flash_prog_ctrl #(
        .WE_CYC(WE), .BSY_WAIT(BSYW), .TIMEOUT_W(TW), .RD_CYC(RD)
    ) dut (
        .CLKCPU(CLKCPU), .RESET(RESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .FLASH_BUSY_n(FLASH_BUSY_n), .flash_q(flash_q),
        .flash_a(flash_a), .flash_d(flash_d), .flash_d_oe(flash_d_oe),
        .flash_ce_n(flash_ce_n), .flash_we_n(flash_we_n), .flash_oe_n(flash_oe_n),
        .busy(busy), .done(done), .error(error)
    );

    int assert_cnt = 0;
    int fail_cnt   = 0;

    // Bus monitor: one entry per completed WE pulse.
    logic [19:0] mon_a[$];
    logic [15:0] mon_d[$];
    int          mon_len[$];
    bit          mon_drv[$];
    int          mon_run = 0;
    int          mon_oe  = 0;
    int          mon_ovl = 0;

    always @(negedge CLKCPU) begin
        if (!flash_we_n) begin
            mon_run++;
        end else if (mon_run > 0) begin
            mon_a.push_back(flash_a);
            mon_d.push_back(flash_d);
            mon_len.push_back(mon_run);
            mon_drv.push_back(flash_d_oe && !flash_ce_n);
            mon_run = 0;
        end
        if (!flash_oe_n) mon_oe++;
        if (!flash_oe_n && flash_d_oe) mon_ovl++;
    end

    // Reference write list straight from the command tables.
    logic [19:0] exp_a[$];
    logic [15:0] exp_d[$];

    task automatic build_expected(input logic [1:0] op, input logic [19:0] addr,
                                  input logic [15:0] data);
        exp_a.delete();
        exp_d.delete();
        if (op == 2'b11) begin
            exp_a.push_back(addr); exp_d.push_back(16'h00F0);
        end else begin
            exp_a.push_back(20'h555); exp_d.push_back(16'h00AA);
            exp_a.push_back(20'h2AA); exp_d.push_back(16'h0055);
            if (op == 2'b00) begin
                exp_a.push_back(20'h555); exp_d.push_back(16'h00A0);
                exp_a.push_back(addr);    exp_d.push_back(data);
            end else begin
                exp_a.push_back(20'h555); exp_d.push_back(16'h0080);
                exp_a.push_back(20'h555); exp_d.push_back(16'h00AA);
                exp_a.push_back(20'h2AA); exp_d.push_back(16'h0055);
                exp_a.push_back((op == 2'b01) ? addr : 20'h555);
                exp_d.push_back((op == 2'b01) ? 16'h0030 : 16'h0010);
            end
        end
    endtask

    function automatic bit busy_low(input int c, input int fall, input int len);
        return (fall >= 0) && (c >= fall) && ((len < 0) || (c < fall + len));
    endfunction

    // Timeline model: cycle 1 is the first cycle after the accepting edge.
    task automatic model_cmd(input logic [1:0] op, input logic [15:0] data,
                             input logic [15:0] q, input int fall, input int len,
                             output int dc, output bit err, output int oe);
        int w, e, rdy;
        bit found;
        w   = ((op == 2'b00) ? 4 : (op == 2'b11) ? 1 : 6) * (WE + 3);
        err = 1'b0;
        oe  = 0;
        if (op == 2'b11) begin
            dc = w + 1;
            return;
        end
        found = 1'b0;
        e     = 0;
        for (int c = w + 1; c <= w + BSYW; c++) begin
            if (!found && busy_low(c, fall, len)) begin
                found = 1'b1;
                e     = c + 1;
            end
        end
        rdy = w + BSYW + 1;
        if (found) begin
            rdy = -1;
            for (int r = e; r <= e + (2 ** TW) - 2; r++)
                if (rdy < 0 && !busy_low(r, fall, len)) rdy = r + 1;
            if (rdy < 0) begin
                dc  = e + (2 ** TW) - 1;
                err = 1'b1;
                return;
            end
        end
        dc = rdy;
`ifdef FLASH_PROG_VERIFY_EN
        if (op == 2'b00) begin
            dc  = rdy + RD;
            err = (q != data);
            oe  = RD;
        end
`else
        if (q == data) dc = rdy;
`endif
    endtask

    // Runs one command against the model and checks everything observable.
    task automatic do_cmd(input string name, input logic [1:0] op, input logic [19:0] addr,
                          input logic [15:0] data, input int fall, input int len,
                          input int hold_valid, input logic [15:0] q);
        int  dc_exp, oe_exp, dc_got;
        bit  err_exp;
        logic err_got;
        build_expected(op, addr, data);
        model_cmd(op, data, q, fall, len, dc_exp, err_exp, oe_exp);
        dc_got  = -1;
        err_got = 1'b0;
        flash_q = q;
        @(posedge CLKCPU); #1;
        mon_a.delete(); mon_d.delete(); mon_len.delete(); mon_drv.delete();
        mon_run = 0; mon_oe = 0; mon_ovl = 0;
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_data = data;
        FLASH_BUSY_n = 1'b1;
        for (int cyc = 1; cyc <= dc_exp + 20; cyc++) begin
            @(posedge CLKCPU); #1;
            FLASH_BUSY_n = !busy_low(cyc, fall, len);
            cmd_valid = (cyc < hold_valid);
            cmd_op    = 2'($urandom);
            cmd_addr  = 20'($urandom);
            cmd_data  = 16'($urandom);
            @(negedge CLKCPU);
            if (cyc == 1) begin
                assert_cnt++;
                if (cmd_ready !== 1'b0 || busy !== 1'b1 || error !== 1'b0) begin
                    fail_cnt++;
                    $display("FAIL %s accept: ready/busy/error got %b%b%b want 010",
                             name, cmd_ready, busy, error);
                end
            end
            if (done === 1'b1) begin
                dc_got  = cyc;
                err_got = error;
                break;
            end
        end
        cmd_valid = 1'b0;
        assert_cnt++;
        if (dc_got !== dc_exp) begin
            fail_cnt++;
            $display("FAIL %s done_cycle: got %0d want %0d", name, dc_got, dc_exp);
        end
        assert_cnt++;
        if (err_got !== err_exp) begin
            fail_cnt++;
            $display("FAIL %s error: got %b want %b", name, err_got, err_exp);
        end
        assert_cnt++;
        if (mon_a.size() !== exp_a.size()) begin
            fail_cnt++;
            $display("FAIL %s write_count: got %0d want %0d", name, mon_a.size(), exp_a.size());
        end else begin
            for (int i = 0; i < exp_a.size(); i++) begin
                assert_cnt++;
                if (mon_a[i] !== exp_a[i] || mon_d[i] !== exp_d[i] ||
                    mon_len[i] !== WE || mon_drv[i] !== 1'b1) begin
                    fail_cnt++;
                    $display("FAIL %s write%0d: got %h/%h len %0d drv %b want %h/%h len %0d drv 1",
                             name, i, mon_a[i], mon_d[i], mon_len[i], mon_drv[i],
                             exp_a[i], exp_d[i], WE);
                end
            end
        end
        assert_cnt++;
        if (mon_oe !== oe_exp || mon_ovl !== 0) begin
            fail_cnt++;
            $display("FAIL %s read_strobe: oe cycles %0d overlap %0d want %0d and 0",
                     name, mon_oe, mon_ovl, oe_exp);
        end
        @(posedge CLKCPU); #1;
        FLASH_BUSY_n = 1'b1;
        @(negedge CLKCPU);
        assert_cnt++;
        if (done !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0 || flash_ce_n !== 1'b1) begin
            fail_cnt++;
            $display("FAIL %s after_done: done/ready/busy/ce_n got %b%b%b%b want 0101",
                     name, done, cmd_ready, busy, flash_ce_n);
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (3) @(posedge CLKCPU);
        #1 RESET = 1'b0;
        @(negedge CLKCPU);
        assert_cnt++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
            fail_cnt++;
            $display("FAIL reset_status: ready/busy/done/error got %b%b%b%b want 1000",
                     cmd_ready, busy, done, error);
        end
        assert_cnt++;
        if (flash_ce_n !== 1'b1 || flash_we_n !== 1'b1 || flash_oe_n !== 1'b1 ||
            flash_d_oe !== 1'b0) begin
            fail_cnt++;
            $display("FAIL reset_strobes: ce/we/oe/doe got %b%b%b%b want 1110",
                     flash_ce_n, flash_we_n, flash_oe_n, flash_d_oe);
        end
        assert_cnt++;
        if (flash_a !== 20'h0 || flash_d !== 16'h0) begin
            fail_cnt++;
            $display("FAIL reset_bus: a/d got %h/%h want 00000/0000", flash_a, flash_d);
        end
    endtask

    task automatic test_program();
        do_cmd("program", 2'b00, 20'h12345, 16'hBEEF, 21, 10, 0, 16'hBEEF);
    endtask

    task automatic test_sector_erase();
        do_cmd("sector_erase", 2'b01, 20'h40000, 16'h1234, 31, 6, 0, 16'h0);
    endtask

    task automatic test_chip_erase();
        do_cmd("chip_erase", 2'b10, 20'h7FFFF, 16'h0, 33, 4, 5, 16'h0);
    endtask

    task automatic test_read_reset();
        do_cmd("read_reset", 2'b11, 20'hABCDE, 16'h5A5A, -1, 0, 3, 16'h0);
    endtask

    task automatic test_no_busy();
        do_cmd("no_busy", 2'b00, 20'h00001, 16'h8001, -1, 0, 0, 16'h8001);
    endtask

    task automatic test_timeout();
        do_cmd("timeout", 2'b01, 20'h40000, 16'h0, 32, -1, 0, 16'h0);
    endtask

    task automatic test_reset_mid();
        int dones;
        dones = 0;
        @(posedge CLKCPU); #1;
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_addr = 20'h12345; cmd_data = 16'hBEEF;
        @(posedge CLKCPU); #1;
        cmd_valid = 1'b0;
        repeat (6) @(posedge CLKCPU);
        @(negedge CLKCPU);
        assert_cnt++;
        if (flash_we_n !== 1'b0) begin
            fail_cnt++;
            $display("FAIL reset_mid_pulse: we_n got %b want 0", flash_we_n);
        end
        RESET = 1'b1;
        @(posedge CLKCPU); #1;
        RESET = 1'b0;
        @(negedge CLKCPU);
        assert_cnt++;
        if (flash_we_n !== 1'b1 || flash_ce_n !== 1'b1 || cmd_ready !== 1'b1 ||
            busy !== 1'b0 || flash_d_oe !== 1'b0 || flash_a !== 20'h0) begin
            fail_cnt++;
            $display("FAIL reset_mid_outputs: we/ce/ready/busy/doe got %b%b%b%b%b a %h want 11100 a 00000",
                     flash_we_n, flash_ce_n, cmd_ready, busy, flash_d_oe, flash_a);
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge CLKCPU);
            if (done === 1'b1) dones++;
        end
        assert_cnt++;
        if (dones !== 0) begin
            fail_cnt++;
            $display("FAIL reset_mid_done: done pulses got %0d want 0", dones);
        end
    endtask

`ifdef FLASH_PROG_VERIFY_EN
    task automatic test_verify();
        do_cmd("verify_bad", 2'b00, 20'h00100, 16'h00FF, 21, 3, 0, 16'h00FE);
        do_cmd("verify_good", 2'b00, 20'h00100, 16'h00FF, 21, 3, 0, 16'h00FF);
    endtask
`endif

    task automatic test_random();
        logic [1:0]  op;
        logic [15:0] data;
        int          w, fall, len, hold;
        for (int n = 0; n < 16; n++) begin
            op   = 2'($urandom);
            data = 16'($urandom);
            w    = ((op == 2'b00) ? 4 : (op == 2'b11) ? 1 : 6) * (WE + 3);
            fall = ($urandom_range(0, 4) == 0) ? -1 : w - 3 + int'($urandom_range(0, 12));
            len  = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(1, 25));
            hold = int'($urandom_range(0, w - 1));
            do_cmd("random", op, 20'($urandom), data, fall, len, hold,
                   ($urandom_range(0, 1) == 0) ? data : 16'($urandom));
        end
    endtask

    initial begin
        RESET = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = 20'h0;
        cmd_data = 16'h0; FLASH_BUSY_n = 1'b1; flash_q = 16'h0;
        test_reset();
        test_program();
        test_sector_erase();
        test_chip_erase();
        test_read_reset();
        test_no_busy();
        test_timeout();
        test_reset_mid();
`ifdef FLASH_PROG_VERIFY_EN
        test_verify();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
